// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx
//   Sends one 10-bit LCD word {RS, RW, byte[7:0]} over a 4-bit HD44780-style
//   bus as two nibbles (upper first). Each nibble is framed by setup / enable
//   pulse / hold phases. A gap separates the nibbles and an execution wait
//   follows the byte. A one-cycle done pulse ends every accepted transfer.
//
//   Optional build macro: LCD_CLEAR_WAIT_EN
//     When defined, a command byte 8'h01 (clear) or 8'h02 (home) with RS=0
//     uses the long T_CLEAR execution wait instead of T_WAIT.
//
// Ports
//   clk              single clock (50 MHz)
//   reset            synchronous, active-high
//   data[9:0]        {RS, RW, byte}; latched when a transfer is accepted
//   en               level-sensitive transfer request, sampled in IDLE
//   LCD_E            enable strobe, high only while a nibble pulse is active
//   LCD_RS, LCD_RW   latched RS/RW from the upper-nibble setup to the
//                    lower-nibble hold, 0 otherwise
//   SF_D11..SF_D8    4-bit data bus, SF_D11 is the MSB
//   done             one-cycle pulse at the end of a transfer
module lcd_nibble_tx #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 50,
  parameter int T_WAIT  = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       en,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       SF_D11,
  output logic       SF_D10,
  output logic       SF_D9,
  output logic       SF_D8,
  output logic       done
);

  // Counter must cover the longest phase; never narrower than 17 bits.
  localparam int T_MAX_A = (T_WAIT > T_CLEAR) ? T_WAIT : T_CLEAR;
  localparam int T_MAX   = (T_MAX_A > T_GAP) ? T_MAX_A : T_GAP;
  localparam int CNT_W   = ($clog2(T_MAX + 1) > 17) ? $clog2(T_MAX + 1) : 17;

  // Counter holds "cycles remaining minus one" for the current phase.
  localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] WAIT_M1  = CNT_W'(T_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE, HI_SETUP, HI_PULSE, HI_HOLD, GAP,
    LO_SETUP, LO_PULSE, LO_HOLD, WAIT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       latch_q, latch_d;
  logic [CNT_W-1:0] wait_m1;
  logic [3:0]       sf_q, sf_d;
  logic             e_d, rs_d, rw_d, done_d;

`ifdef LCD_CLEAR_WAIT_EN
  localparam logic [CNT_W-1:0] CLEAR_M1 = CNT_W'(T_CLEAR - 1);
  logic is_clear;
  // Clear and home commands need the long execution time.
  assign is_clear = !latch_q[9] && ((latch_q[7:0] == 8'h01) || (latch_q[7:0] == 8'h02));
  assign wait_m1  = is_clear ? CLEAR_M1 : WAIT_M1;
`else
  assign wait_m1  = WAIT_M1;
`endif

  // Next-state / counter / latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          latch_d = data;
          state_d = HI_SETUP;
          cnt_d   = SETUP_M1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          case (state_q)
            HI_SETUP: begin state_d = HI_PULSE; cnt_d = PULSE_M1; end
            HI_PULSE: begin state_d = HI_HOLD;  cnt_d = HOLD_M1;  end
            HI_HOLD:  begin state_d = GAP;      cnt_d = GAP_M1;   end
            GAP:      begin state_d = LO_SETUP; cnt_d = SETUP_M1; end
            LO_SETUP: begin state_d = LO_PULSE; cnt_d = PULSE_M1; end
            LO_PULSE: begin state_d = LO_HOLD;  cnt_d = HOLD_M1;  end
            LO_HOLD:  begin state_d = WAIT;     cnt_d = wait_m1;  end
            WAIT:     begin state_d = DONE;     cnt_d = '0;       end
            default:  begin state_d = IDLE;     cnt_d = '0;       end
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the state they describe.
  always_comb begin
    e_d    = (state_d == HI_PULSE) || (state_d == LO_PULSE);
    rs_d   = 1'b0;
    rw_d   = 1'b0;
    sf_d   = 4'h0;
    done_d = (state_d == DONE);
    case (state_d)
      HI_SETUP, HI_PULSE, HI_HOLD: begin
        rs_d = latch_d[9];
        rw_d = latch_d[8];
        sf_d = latch_d[7:4];
      end
      GAP: begin
        rs_d = latch_d[9];
        rw_d = latch_d[8];
      end
      LO_SETUP, LO_PULSE, LO_HOLD: begin
        rs_d = latch_d[9];
        rw_d = latch_d[8];
        sf_d = latch_d[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
      sf_q    <= 4'h0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      LCD_E   <= e_d;
      LCD_RS  <= rs_d;
      LCD_RW  <= rw_d;
      sf_q    <= sf_d;
      done    <= done_d;
    end
  end

  assign SF_D11 = sf_q[3];
  assign SF_D10 = sf_q[2];
  assign SF_D9  = sf_q[1];
  assign SF_D8  = sf_q[0];

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Directed testbench for lcd_nibble_tx with default timing parameters.
// Edge numbering: the acceptance edge of a transfer is edge 1, so with the
// defaults the first LCD_E rise is edge 3, the lower nibble rises at edge 68,
// WAIT starts at edge 81 and done rises at edge 2081.
module tb_lcd_nibble_tx;

  logic       clk;
  logic       reset;
  logic [9:0] data;
  logic       en;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic       SF_D11, SF_D10, SF_D9, SF_D8;
  logic       done;
  logic [3:0] sf;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef LCD_CLEAR_WAIT_EN
  localparam int CLR_DONE = 82081;
`else
  localparam int CLR_DONE = 2081;
`endif

  assign sf = {SF_D11, SF_D10, SF_D9, SF_D8};

  lcd_nibble_tx dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .en     (en),
    .LCD_E  (LCD_E),
    .LCD_RS (LCD_RS),
    .LCD_RW (LCD_RW),
    .SF_D11 (SF_D11),
    .SF_D10 (SF_D10),
    .SF_D9  (SF_D9),
    .SF_D8  (SF_D8),
    .done   (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer at the current negedge (state must be IDLE) and
  // watches it until done. At edge drop_at, en is dropped and data replaced
  // by alt_d (drop_at = 0 keeps en high). Returns at the negedge showing done.
  task automatic xfer(input string tag, input logic [9:0] d, input int done_exp,
                      input int drop_at, input logic [9:0] alt_d);
    int rise_n, rise_tot, done_at;
    int rise_at [2];
    int plen    [2];
    logic [3:0] sfv [2];
    logic       rsv [2];
    logic [3:0] sf15, sf16;
    logic       rs81, rw_any, e_prev;
    rise_n = 0; rise_tot = 0; done_at = 0;
    rise_at[0] = 0; rise_at[1] = 0; plen[0] = 0; plen[1] = 0;
    sfv[0] = 4'hx; sfv[1] = 4'hx; rsv[0] = 1'bx; rsv[1] = 1'bx;
    sf15 = 4'hx; sf16 = 4'hx; rs81 = 1'bx; rw_any = 1'b0; e_prev = 1'b0;
    data = d;
    en   = 1'b1;
    for (int k = 1; k <= done_exp + 20 && done_at == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == drop_at) begin
        en   = 1'b0;
        data = alt_d;
      end
      if (LCD_E && !e_prev) begin
        rise_tot++;
        if (rise_n < 2) begin
          rise_at[rise_n] = k;
          sfv[rise_n]     = sf;
          rsv[rise_n]     = LCD_RS;
          rise_n++;
        end
      end
      if (LCD_E && rise_n > 0 && rise_tot <= 2) plen[rise_n-1]++;
      e_prev = LCD_E;
      if (LCD_RW) rw_any = 1'b1;
      if (k == 15) sf15 = sf;
      if (k == 16) sf16 = sf;
      if (k == 81) rs81 = LCD_RS;
      if (done) done_at = k;
    end
    chk({tag, " hi_rise_edge"}, rise_at[0], 3);
    chk({tag, " hi_nibble"},    sfv[0], d[7:4]);
    chk({tag, " hi_pulse_len"}, plen[0], 12);
    chk({tag, " hi_hold_sf"},   sf15, d[7:4]);
    chk({tag, " gap_sf"},       sf16, 4'h0);
    chk({tag, " lo_rise_edge"}, rise_at[1], 68);
    chk({tag, " lo_nibble"},    sfv[1], d[3:0]);
    chk({tag, " lo_pulse_len"}, plen[1], 12);
    chk({tag, " rs_hi"},        rsv[0], d[9]);
    chk({tag, " rs_lo"},        rsv[1], d[9]);
    chk({tag, " rw_seen"},      rw_any, d[8]);
    chk({tag, " wait_rs"},      rs81, 1'b0);
    chk({tag, " e_rises"},      rise_tot, 2);
    chk({tag, " done_edge"},    done_at, done_exp);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    en    = 1'b1;
    data  = 10'h3FF;

    // Reset holds everything low even with a request present.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {LCD_E, LCD_RS, LCD_RW, sf, done}, 8'h00);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || LCD_E) cnt++;
    end
    chk("idle_no_done", cnt, 0);

    // Command 0x28, en pulsed for one cycle.
    xfer("cmd28", 10'h028, 2081, 1, 10'h028);
    @(negedge clk);
    chk("cmd28 done_width", done, 1'b0);

    // Character 'A' with RS=1.
    xfer("charA", 10'h241, 2081, 1, 10'h241);
    @(negedge clk);
    chk("charA done_width", done, 1'b0);

    // Clear display command.
    xfer("clear", 10'h001, CLR_DONE, 1, 10'h001);
    @(negedge clk);
    chk("clear done_width", done, 1'b0);

    // Back-to-back: en held high, new data only in the IDLE cycle.
    xfer("b2b_a", 10'h2C5, 2081, 0, 10'h000);
    @(negedge clk);
    chk("b2b idle_done_low", done, 1'b0);
    xfer("b2b_b", 10'h13A, 2081, 1, 10'h13A);
    @(negedge clk);
    chk("b2b_b done_width", done, 1'b0);

    // Data changed and en dropped during GAP.
    xfer("gapchg", 10'h2A7, 2081, 30, 10'h3FF);
    @(negedge clk);
    chk("gapchg done_width", done, 1'b0);

    // Reset during LO_PULSE aborts the transfer without done.
    data = 10'h028;
    en   = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) en = 1'b0;
    end
    chk("abort in_lo_pulse", {LCD_E, sf}, 5'h18);
    reset = 1'b1;
    @(negedge clk);
    chk("abort outputs", {LCD_E, LCD_RS, LCD_RW, sf, done}, 8'h00);
    reset = 1'b0;
    cnt = 0;
    repeat (2200) begin
      @(negedge clk);
      if (done || LCD_E) cnt++;
    end
    chk("abort no_done", cnt, 0);

    xfer("after_abort", 10'h028, 2081, 1, 10'h028);
    @(negedge clk);
    chk("after_abort done_width", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
